// File: rtl/sccb_reg_sequencer.sv
// SCCB register sequencer: runs an init table from ROM, then serves HCI address
// stepping, register writes and two-phase register reads through an AXI-stream i2c master.
module sccb_reg_sequencer #(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         COARSE_STEP = 16,
  parameter int         INIT_DEPTH  = 64,
  parameter int         TIMEOUT     = 2**20,
  localparam int        IW          = $clog2(INIT_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          btn_l,
  input  logic          btn_r,
  input  logic          btn_u,
  input  logic          btn_d,
  input  logic          btn_c,
  input  logic          btn_rd,
  input  logic [7:0]    switches,
  input  logic          init_start,
  output logic [IW-1:0] rom_idx,
  input  logic [7:0]    rom_addr,
  input  logic [7:0]    rom_data,
  output logic [7:0]    cur_addr,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          error,
  output logic [6:0]    s_axis_cmd_address,
  output logic          s_axis_cmd_start,
  output logic          s_axis_cmd_read,
  output logic          s_axis_cmd_write,
  output logic          s_axis_cmd_write_multiple,
  output logic          s_axis_cmd_stop,
  output logic          s_axis_cmd_valid,
  input  logic          s_axis_cmd_ready,
  output logic [7:0]    s_axis_data_tdata,
  output logic          s_axis_data_tvalid,
  output logic          s_axis_data_tlast,
  input  logic          s_axis_data_tready,
  input  logic [7:0]    m_axis_data_tdata,
  input  logic          m_axis_data_tvalid,
  input  logic          m_axis_data_tlast,
  output logic          m_axis_data_tready
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    STEP     = 8'(COARSE_STEP);
  localparam logic [IW-1:0] LAST_IDX = IW'(INIT_DEPTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, INIT_FETCH, INIT_CHK, W_CMD, W_ADDR, W_DATA, R_CMDW, R_ADDR, R_CMDR, R_WAIT
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tmo_cnt;
  logic          handshake_st, tmo_fire, in_init;
  logic [7:0]    wr_reg, wr_val;
  logic          unused_tlast;

  assign s_axis_cmd_address = DEV_ADDR;
  assign unused_tlast       = m_axis_data_tlast;

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) state <= INIT_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n                   = state;
    handshake_st              = 1'b0;
    tmo_fire                  = 1'b0;
    s_axis_cmd_valid          = 1'b0;
    s_axis_cmd_start          = 1'b0;
    s_axis_cmd_read           = 1'b0;
    s_axis_cmd_write          = 1'b0;
    s_axis_cmd_write_multiple = 1'b0;
    s_axis_cmd_stop           = 1'b0;
    s_axis_data_tvalid        = 1'b0;
    s_axis_data_tdata         = 8'h00;
    s_axis_data_tlast         = 1'b0;
    m_axis_data_tready        = 1'b0;
    case (state)
      IDLE: begin
        if (init_start)  state_n = INIT_FETCH;
        else if (btn_c)  state_n = W_CMD;
        else if (btn_rd) state_n = R_CMDW;
      end
      INIT_FETCH: state_n = INIT_CHK;
      INIT_CHK:   state_n = (rom_addr == 8'hFF) ? IDLE : W_CMD;
      W_CMD, R_CMDW: begin
        handshake_st              = 1'b1;
        s_axis_cmd_valid          = 1'b1;
        s_axis_cmd_start          = 1'b1;
        s_axis_cmd_write_multiple = 1'b1;
        s_axis_cmd_stop           = 1'b1;
        if (s_axis_cmd_ready) state_n = (state == W_CMD) ? W_ADDR : R_ADDR;
      end
      W_ADDR: begin
        handshake_st       = 1'b1;
        s_axis_data_tvalid = 1'b1;
        s_axis_data_tdata  = wr_reg;
        if (s_axis_data_tready) state_n = W_DATA;
      end
      W_DATA: begin
        handshake_st       = 1'b1;
        s_axis_data_tvalid = 1'b1;
        s_axis_data_tdata  = wr_val;
        s_axis_data_tlast  = 1'b1;
        // During init, the final table slot ends the run even without an end marker.
        if (s_axis_data_tready)
          state_n = (in_init && rom_idx != LAST_IDX) ? INIT_FETCH : IDLE;
      end
      R_ADDR: begin
        handshake_st       = 1'b1;
        s_axis_data_tvalid = 1'b1;
        s_axis_data_tdata  = cur_addr;
        s_axis_data_tlast  = 1'b1;
        if (s_axis_data_tready) state_n = R_CMDR;
      end
      R_CMDR: begin
        handshake_st     = 1'b1;
        s_axis_cmd_valid = 1'b1;
        s_axis_cmd_start = 1'b1;
        s_axis_cmd_read  = 1'b1;
        s_axis_cmd_stop  = 1'b1;
        if (s_axis_cmd_ready) state_n = R_WAIT;
      end
      R_WAIT: begin
        handshake_st       = 1'b1;
        m_axis_data_tready = 1'b1;
        if (m_axis_data_tvalid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (handshake_st && state_n == state && tmo_cnt == TMO_LAST) begin
      state_n  = IDLE;
      tmo_fire = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      rom_idx  <= '0;
      cur_addr <= 8'h00;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
      in_init  <= 1'b1;
      tmo_cnt  <= '0;
    end else begin
      busy     <= (state_n != IDLE);
      rd_valid <= (state == R_WAIT) && m_axis_data_tvalid;
      if (state == R_WAIT && m_axis_data_tvalid) rd_data <= m_axis_data_tdata;
      tmo_cnt  <= (state_n != state || !handshake_st) ? '0 : tmo_cnt + 1'b1;
      if (tmo_fire)
        error <= 1'b1;
      else if (state == IDLE && (init_start || btn_c || btn_rd))
        error <= 1'b0;
      if (state == IDLE) begin
        in_init <= init_start;
        if (init_start) rom_idx <= '0;
        else if (!btn_c && !btn_rd) begin
          if (btn_r)      cur_addr <= cur_addr + 8'd1;
          else if (btn_l) cur_addr <= cur_addr - 8'd1;
          else if (btn_u) cur_addr <= cur_addr + STEP;
          else if (btn_d) cur_addr <= cur_addr - STEP;
        end
      end
      if (state == W_DATA && s_axis_data_tready && in_init && rom_idx != LAST_IDX)
        rom_idx <= rom_idx + 1'b1;
    end
  end

  // Write operands: HCI values are tracked while idle so btn_c captures that cycle's switches.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        wr_reg <= cur_addr;
        wr_val <= switches;
      end
      INIT_CHK: begin
        wr_reg <= rom_addr;
        wr_val <= rom_data;
      end
      default: ;
    endcase
  end

endmodule
